// File: rtl/mask_accumulator.sv
// Accumulates enabled address lanes into a multi-hot mask over a frame of beats,
// then holds the mask, its popcount and sticky err/dup flags until consumed.
module mask_accumulator #(
    parameter int SIZE = 8,
    parameter int K = 4,
    localparam int BIT = $clog2(SIZE),
    localparam int CNT_W = $clog2(SIZE + 1)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [K*BIT-1:0]   in_addr,
    input  logic [K-1:0]       in_lane_en,
    input  logic               in_last,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [SIZE-1:0]    out_mask,
    output logic [CNT_W-1:0]   out_count,
    output logic               out_err,
    output logic               out_dup,
    output logic               dbg_state
);

    // Handshake: a transfer happens on a rising edge where valid and ready are both 1;
    // ready never depends on valid, and a presented beat/result stays put until taken.
    typedef enum logic {ACCUM = 1'b0, HOLD = 1'b1} state_t;

    state_t state, state_next;

    logic [SIZE-1:0]  acc;
    logic [CNT_W-1:0] count;
    logic             err, dup;

    logic [BIT-1:0]   lane_addr [K];
    logic [SIZE-1:0]  beat_mask;
    logic             beat_err, beat_dup;
    logic [SIZE-1:0]  acc_next;
    logic [CNT_W-1:0] count_next;
    logic             accept, consume;

    assign accept  = in_valid && (state == ACCUM);
    assign consume = out_ready && (state == HOLD);

    // Lanes are folded in index order so a later lane sees bits set by lower lanes.
    always_comb begin
        beat_mask = '0;
        beat_err  = 1'b0;
        beat_dup  = 1'b0;
        for (int i = 0; i < K; i++) begin
            lane_addr[i] = in_addr[BIT*i +: BIT];
            if (in_lane_en[i]) begin
                if (int'(lane_addr[i]) >= SIZE) begin
                    beat_err = 1'b1;
                end else begin
                    if (acc[lane_addr[i]] || beat_mask[lane_addr[i]])
                        beat_dup = 1'b1;
                    beat_mask[lane_addr[i]] = 1'b1;
                end
            end
        end
    end

    always_comb begin
        acc_next   = acc | beat_mask;
        count_next = '0;
        for (int j = 0; j < SIZE; j++)
            count_next = count_next + CNT_W'(acc_next[j]);
    end

    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        case (state)
            ACCUM: begin
                in_ready = 1'b1;
                if (accept && in_last)
                    state_next = HOLD;
            end
            HOLD: begin
                out_valid = 1'b1;
                if (consume)
                    state_next = ACCUM;
            end
            default: state_next = ACCUM;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= ACCUM;
        else
            state <= state_next;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc   <= '0;
            count <= '0;
            err   <= 1'b0;
            dup   <= 1'b0;
        end else if (consume) begin
            acc   <= '0;
            count <= '0;
            err   <= 1'b0;
            dup   <= 1'b0;
        end else if (accept) begin
            acc   <= acc_next;
            count <= count_next;
            err   <= err | beat_err;
            dup   <= dup | beat_dup;
        end
    end

    assign out_mask  = acc;
    assign out_count = count;
    assign out_err   = err;
    assign out_dup   = dup;
    assign dbg_state = (state == HOLD);

endmodule

// File: tb/tb_mask_accumulator.sv
// Directed bench for mask_accumulator: a vector table on an 8-wide/4-lane instance
// plus hand sequences for hold/backpressure, reset and out-of-range lanes (6-wide/3-lane).
module tb_mask_accumulator;

    logic clk;
    logic rst;

    logic        in_valid8, in_ready8, in_last8, out_valid8, out_ready8, out_err8, out_dup8, dbg8;
    logic [11:0] in_addr8;
    logic [3:0]  in_en8;
    logic [7:0]  out_mask8;
    logic [3:0]  out_count8;

    logic        in_valid6, in_ready6, in_last6, out_valid6, out_ready6, out_err6, out_dup6, dbg6;
    logic [8:0]  in_addr6;
    logic [2:0]  in_en6;
    logic [5:0]  out_mask6;
    logic [2:0]  out_count6;

    int n_total = 0;
    int n_pass  = 0;

    mask_accumulator #(.SIZE(8), .K(4)) dut8 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid8), .in_ready(in_ready8), .in_addr(in_addr8),
        .in_lane_en(in_en8), .in_last(in_last8),
        .out_valid(out_valid8), .out_ready(out_ready8), .out_mask(out_mask8),
        .out_count(out_count8), .out_err(out_err8), .out_dup(out_dup8),
        .dbg_state(dbg8)
    );

    mask_accumulator #(.SIZE(6), .K(3)) dut6 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid6), .in_ready(in_ready6), .in_addr(in_addr6),
        .in_lane_en(in_en6), .in_last(in_last6),
        .out_valid(out_valid6), .out_ready(out_ready6), .out_mask(out_mask6),
        .out_count(out_count6), .out_err(out_err6), .out_dup(out_dup6),
        .dbg_state(dbg6)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic [11:0] addr;
        logic [3:0]  en;
        logic        last;
        logic [7:0]  mask;
        logic [3:0]  cnt;
        logic        err;
        logic        dup;
    } vec_t;

    vec_t vecs[8];

    function automatic vec_t mk(int a0, int a1, int a2, int a3, logic [3:0] en, logic last,
                                logic [7:0] m, int c, logic e, logic d);
        vec_t v;
        v.addr = {3'(a3), 3'(a2), 3'(a1), 3'(a0)};
        v.en   = en;
        v.last = last;
        v.mask = m;
        v.cnt  = 4'(c);
        v.err  = e;
        v.dup  = d;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp)
            n_pass++;
        else
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    task automatic beat8(input logic [11:0] addr, input logic [3:0] en, input logic last);
        in_valid8 = 1'b1;
        in_addr8  = addr;
        in_en8    = en;
        in_last8  = last;
        @(posedge clk);
        #1;
        in_valid8 = 1'b0;
        in_last8  = 1'b0;
    endtask

    task automatic consume8(input string tag);
        out_ready8 = 1'b1;
        @(posedge clk);
        #1;
        out_ready8 = 1'b0;
        chk({tag, "_cons_valid"}, out_valid8, 0);
        chk({tag, "_cons_ready"}, in_ready8, 1);
        chk({tag, "_cons_mask"}, out_mask8, 0);
        chk({tag, "_cons_count"}, out_count8, 0);
        chk({tag, "_cons_flags"}, {out_err8, out_dup8}, 0);
    endtask

    initial begin
        rst = 1'b1;
        in_valid8 = 0; in_addr8 = '0; in_en8 = '0; in_last8 = 0; out_ready8 = 0;
        in_valid6 = 0; in_addr6 = '0; in_en6 = '0; in_last6 = 0; out_ready6 = 0;

        vecs[0] = mk(0, 3, 5, 7, 4'b1111, 1, 8'hA9, 4, 0, 0);
        vecs[1] = mk(1, 1, 2, 2, 4'b1111, 0, 8'h06, 2, 0, 1);
        vecs[2] = mk(2, 6, 7, 7, 4'b0011, 1, 8'h46, 3, 0, 1);
        vecs[3] = mk(7, 7, 7, 7, 4'b0000, 1, 8'h00, 0, 0, 0);
        vecs[4] = mk(1, 7, 7, 7, 4'b0001, 1, 8'h02, 1, 0, 0);
        vecs[5] = mk(0, 1, 2, 3, 4'b1111, 0, 8'h0F, 4, 0, 0);
        vecs[6] = mk(4, 5, 6, 7, 4'b1111, 1, 8'hFF, 8, 0, 0);
        vecs[7] = mk(0, 0, 0, 0, 4'b1001, 1, 8'h01, 1, 0, 1);

        // reset is asynchronous: values are checked before any clock edge
        #3;
        chk("rst_valid", out_valid8, 0);
        chk("rst_ready", in_ready8, 1);
        chk("rst_mask", out_mask8, 0);
        chk("rst_count", out_count8, 0);
        chk("rst_flags", {out_err8, out_dup8, dbg8}, 0);
        chk("rst6_all", {out_valid6, out_mask6, out_count6, out_err6, out_dup6}, 0);
        #19;
        rst = 1'b0;
        @(posedge clk);
        #1;

        for (int i = 0; i < 8; i++) begin
            string tag;
            tag = $sformatf("vec%0d", i);
            beat8(vecs[i].addr, vecs[i].en, vecs[i].last);
            chk({tag, "_valid"}, out_valid8, vecs[i].last);
            chk({tag, "_ready"}, in_ready8, !vecs[i].last);
            chk({tag, "_mask"}, out_mask8, vecs[i].mask);
            chk({tag, "_count"}, out_count8, vecs[i].cnt);
            chk({tag, "_err"}, out_err8, vecs[i].err);
            chk({tag, "_dup"}, out_dup8, vecs[i].dup);
            if (vecs[i].last)
                consume8(tag);
        end

        // backpressure: result holds while in_valid is asserted and nothing is absorbed
        beat8({3'd0, 3'd0, 3'd0, 3'd1}, 4'b0001, 1);
        in_valid8 = 1'b1;
        in_addr8  = {3'd0, 3'd0, 3'd0, 3'd5};
        in_en8    = 4'b0001;
        in_last8  = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk);
            #1;
            chk($sformatf("hold%0d_state", c), {out_valid8, in_ready8, dbg8}, 3'b101);
            chk($sformatf("hold%0d_mask", c), out_mask8, 8'h02);
            chk($sformatf("hold%0d_count", c), out_count8, 1);
        end
        out_ready8 = 1'b1;
        @(posedge clk);
        #1;
        out_ready8 = 1'b0;
        chk("hold_cons_state", {out_valid8, in_ready8}, 2'b01);
        chk("hold_cons_mask", out_mask8, 0);
        @(posedge clk);
        #1;
        in_valid8 = 1'b0;
        chk("after_cons_mask", out_mask8, 8'h20);
        chk("after_cons_valid", out_valid8, 0);
        beat8('0, 4'b0000, 1);
        chk("after_cons_close", {out_valid8, out_mask8}, {1'b1, 8'h20});
        consume8("after_cons");

        // reset mid-frame, with out_ready high in ACCUM having no effect
        out_ready8 = 1'b1;
        beat8({3'd0, 3'd0, 3'd0, 3'd4}, 4'b0001, 0);
        out_ready8 = 1'b0;
        chk("mid_mask", out_mask8, 8'h10);
        #2 rst = 1'b1;
        #1;
        chk("mid_rst_out", {out_valid8, in_ready8, out_mask8, out_count8}, {1'b0, 1'b1, 8'h00, 4'h0});
        #1 rst = 1'b0;
        beat8({3'd0, 3'd0, 3'd0, 3'd2}, 4'b0001, 1);
        chk("post_rst_mask", out_mask8, 8'h04);
        chk("post_rst_count", out_count8, 1);
        consume8("post_rst");

        // reset while a result is pending
        beat8({3'd0, 3'd0, 3'd0, 3'd3}, 4'b0001, 1);
        chk("pend_valid", out_valid8, 1);
        #2 rst = 1'b1;
        #1;
        chk("pend_rst_out", {out_valid8, in_ready8, dbg8, out_mask8}, {3'b010, 8'h00});
        #1 rst = 1'b0;
        beat8({3'd0, 3'd0, 3'd0, 3'd0}, 4'b0001, 1);
        chk("pend_after_mask", out_mask8, 8'h01);
        consume8("pend_after");

        // out-of-range lanes on the 6-wide instance
        in_valid6 = 1'b1;
        in_addr6  = {3'd0, 3'd7, 3'd6};
        in_en6    = 3'b111;
        in_last6  = 1'b1;
        @(posedge clk);
        #1;
        in_valid6 = 1'b0;
        in_last6  = 1'b0;
        chk("oor_valid", out_valid6, 1);
        chk("oor_mask", out_mask6, 6'h01);
        chk("oor_count", out_count6, 1);
        chk("oor_err", out_err6, 1);
        chk("oor_dup", out_dup6, 0);
        out_ready6 = 1'b1;
        @(posedge clk);
        #1;
        out_ready6 = 1'b0;
        chk("oor_cons", {out_valid6, out_err6, out_mask6}, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/mask_accumulator.md
MASK_ACCUMULATOR -- requirements
Module: mask_accumulator

Interface
REQ-001 The block SHALL have parameter SIZE, default 8: mask width and address space; SIZE >= 2.
REQ-002 The block SHALL have parameter K, default 4: address lanes per beat; K >= 1.
REQ-003 The block SHALL have localparam BIT = $clog2(SIZE): width of one address lane.
REQ-004 The block SHALL have localparam CNT_W = $clog2(SIZE+1): width of the population count.
REQ-005 The block SHALL have port clk, input, 1: single clock; all state updates on its rising edge.
REQ-006 The block SHALL have port rst, input, 1: asynchronous, active-high reset.
REQ-007 The block SHALL have port in_valid, input, 1: an input beat is presented.
REQ-008 The block SHALL have port in_ready, output, 1: the block can accept a beat.
REQ-009 The block SHALL have port in_addr, input, K*BIT: lane i address at bits [BIT*(i+1)-1 : BIT*i].
REQ-010 The block SHALL have port in_lane_en, input, K: bit i enables lane i.
REQ-011 The block SHALL have port in_last, input, 1: marks the final beat of a frame.
REQ-012 The block SHALL have port out_valid, output, 1: a completed frame result is presented.
REQ-013 The block SHALL have port out_ready, input, 1: the consumer accepts the result.
REQ-014 The block SHALL have port out_mask, output, SIZE: accumulated multi-hot mask.
REQ-015 The block SHALL have port out_count, output, CNT_W: number of set bits in out_mask.
REQ-016 The block SHALL have port out_err, output, 1: an enabled lane held an address >= SIZE in this frame.
REQ-017 The block SHALL have port out_dup, output, 1: an enabled in-range address hit an already-set bit in this frame.

Function
REQ-018 The FSM SHALL have two states: ACCUM (in_ready=1, out_valid=0) and HOLD (in_ready=0, out_valid=1).
REQ-019 A beat SHALL be accepted only on a cycle with in_valid=1 and in_ready=1; in_valid in HOLD SHALL be ignored.
REQ-020 The beat mask SHALL be the OR over enabled lanes i with in_addr lane < SIZE of (1 << lane address); disabled lanes SHALL have no effect.
REQ-021 On an accepted beat, the accumulator SHALL update to acc | beat_mask; the sticky err/dup flags SHALL be ORed with this beat's contributions.
REQ-022 An enabled lane's address >= SIZE SHALL set err and SHALL NOT alter the mask (only reachable when SIZE is not a power of 2).
REQ-023 dup SHALL be set when an enabled in-range lane targets a bit already set in acc, or set by a lower-index enabled lane in the same beat.
REQ-024 out_count SHALL be registered and SHALL equal the popcount of out_mask in every cycle.
REQ-025 An accepted beat with in_last=1 SHALL move the FSM ACCUM->HOLD; out_valid SHALL be 1 on the cycle after that acceptance, with that beat included in the result.
REQ-026 In HOLD, out_mask, out_count, out_err and out_dup SHALL remain stable until out_ready=1.
REQ-027 In HOLD with out_ready=1, the FSM SHALL move to ACCUM and clear acc, count, err and dup on the same edge.
REQ-028 The block SHALL NOT accept a beat on the edge that consumes the result; the earliest next acceptance SHALL be the following cycle.
REQ-029 In ACCUM, out_mask, out_count, out_err and out_dup SHALL show the running partial values; consumers SHALL qualify them with out_valid.
REQ-030 A beat with all lanes disabled SHALL be accepted, leaving acc unchanged; with in_last=1 it SHALL still close the frame.
REQ-031 out_ready SHALL be ignored in ACCUM.

Reset
REQ-032 While rst=1, the block SHALL be in ACCUM with out_valid=0, in_ready=1, out_mask=0, out_count=0, out_err=0 and out_dup=0, effective immediately and independent of clk.
REQ-033 Reset mid-frame or in HOLD SHALL discard all partial or pending results with no residue in later frames.

Verification
REQ-034 The bench SHALL cover: SIZE=8, K=4, one beat with addrs {0,3,5,7}, lanes 1111, last=1 -> next cycle out_valid=1, out_mask=0xA9, out_count=4, out_err=0, out_dup=0.
REQ-035 The bench SHALL cover: SIZE=8, K=4, beat1 {1,1,2,2} with lanes 1111, then beat2 {2,6,x,x} with lanes 0011 and last=1 -> out_mask=0x46, out_count=3, out_dup=1.
REQ-036 The bench SHALL cover: SIZE=6, K=3, one beat {6,7,0} with lanes 111 and last=1 -> out_mask=0x01, out_count=1, out_err=1.
REQ-037 The bench SHALL cover: a HOLD result with out_ready=0 for 3 cycles and in_valid=1 -> outputs stable, in_ready=0, no beat absorbed; then out_ready=1 -> next cycle out_valid=0, out_mask=0, in_ready=1.
REQ-038 The bench SHALL cover: a non-last beat {4,...} followed by a rst pulse between edges -> outputs zero immediately; the next frame {2} with last=1 yields out_mask=0x04.
REQ-039 The bench SHALL cover: a beat with lanes 0000 and last=1 -> out_valid=1, out_mask=0, out_count=0.
